// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: segment patterns and blank levels for the hex scan display
package hex_disp_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [0:15][6:0] SEG_PAT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex_scan_disp_if.sv
// hex_scan_disp_if: capture input and display outputs of the hex scan display
interface hex_scan_disp_if;
  logic [15:0] data;
  logic load;
  logic [6:0] seg;
  logic [3:0] an;
  logic [15:0] shown;
  modport master(output data, load, input seg, an, shown);
  modport slave(input data, load, output seg, an, shown);
endinterface

// File: rtl/hex_to_seg.sv
// hex_to_seg: 4-bit to active-low 7-segment decoder
module hex_to_seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_PAT[nib];
endmodule

// File: rtl/hex_scan_disp.sv
// hex_scan_disp: captures a 16-bit value on load edge and scans it onto four 7-segment digits
module hex_scan_disp
  import hex_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b0
) (
  input logic clk,
  input logic rst_n,
  hex_scan_disp_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic load_q, tick, blank;
  logic [3:0] nib;
  logic [6:0] pat;
  logic [15:0] upper;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign upper = bus.shown >> {idx, 2'b00};
  assign nib = upper[3:0];
  assign blank = BLANK_LZ && idx != 2'd0 && upper == 16'h0000;
  hex_to_seg u_dec (.nib(nib), .seg(pat));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      load_q <= 1'b0;
      bus.shown <= '0;
      bus.seg <= SEG_OFF;
      bus.an <= AN_OFF;
    end else begin
      load_q <= bus.load;
      if (bus.load && !load_q) bus.shown <= bus.data;
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + 2'd1;
      bus.an <= tick ? AN_OFF : ~(4'b0001 << idx);
      bus.seg <= (tick || blank) ? SEG_OFF : pat;
    end
endmodule

// File: tb/tb_hex_scan_disp.sv
// tb_hex_scan_disp: directed checks of capture, scan order, blanking and async reset
module tb_hex_scan_disp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] data = 16'h0000;
  logic load = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  hex_scan_disp_if b0 ();
  hex_scan_disp_if b1 ();
  assign b0.data = data;
  assign b0.load = load;
  assign b1.data = data;
  assign b1.load = load;
  hex_scan_disp #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  hex_scan_disp #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic scan(input string tag, input logic [3:0][6:0] p0, input logic [3:0][6:0] p1);
    for (int i = 0; i < 16; i++) begin
      int slot, dig;
      step();
      slot = (cyc - 1) % 4;
      dig = ((cyc - 1) / 4) % 4;
      chk({tag, " an0"}, b0.an, slot == 3 ? 4'hF : an_seq[dig]);
      chk({tag, " an1"}, b1.an, slot == 3 ? 4'hF : an_seq[dig]);
      chk({tag, " seg0"}, b0.seg, slot == 3 ? 7'h7F : p0[dig]);
      chk({tag, " seg1"}, b1.seg, slot == 3 ? 7'h7F : p1[dig]);
    end
  endtask
  initial begin
    #12;
    chk("rst an", b0.an, 4'hF);
    chk("rst seg", b0.seg, 7'h7F);
    chk("rst shown", b0.shown, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("first an", b0.an, 4'hE);
    chk("first seg", b0.seg, 7'h40);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("order an", b0.an, (cyc - 1) % 4 == 3 ? 4'hF : an_seq[((cyc - 1) / 4) % 4]);
    end
    step();
    chk("wrap an", b0.an, 4'hE);
    data = 16'hA5C3;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("cap shown", b0.shown, 16'hA5C3);
    data = 16'h1111;
    step();
    chk("nolad shown", b0.shown, 16'hA5C3);
    scan("a5c3", {7'h08, 7'h12, 7'h46, 7'h30}, {7'h08, 7'h12, 7'h46, 7'h30});
    data = 16'h0070;
    load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 5) data = 16'h1234;
    end
    load = 1'b0;
    chk("hold shown", b0.shown, 16'h0070);
    chk("hold shown1", b1.shown, 16'h0070);
    scan("0070", {7'h40, 7'h40, 7'h78, 7'h40}, {7'h7F, 7'h7F, 7'h78, 7'h40});
    data = 16'h0000;
    load = 1'b1;
    step();
    load = 1'b0;
    scan("0000", {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    data = 16'hFFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    scan("ffff", {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {7'h0E, 7'h0E, 7'h0E, 7'h0E});
    for (int i = 0; i < 16 && !(((cyc - 1) / 4) % 4 == 2 && (cyc - 1) % 4 != 3); i++) step();
    chk("pre-rst an", b0.an, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst an", b0.an, 4'hF);
    chk("arst seg", b0.seg, 7'h7F);
    chk("arst shown", b0.shown, 16'h0000);
    chk("arst shown1", b1.shown, 16'h0000);
    data = 16'hBEEF;
    load = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step();
    load = 1'b0;
    chk("rel shown", b0.shown, 16'hBEEF);
    chk("rel an", b0.an, 4'hE);
    chk("rel seg", b0.seg, 7'h40);
    step();
    chk("rel seg2", b0.seg, 7'h0E);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_scan_disp.md
# hex_scan_disp

Downstream consumer of the 16-bit pseudo-random generator in the random-hex design. On a rising edge of `load`, it captures the 16-bit value and shows it as four hex digits on a common-anode, time-multiplexed 7-segment display. It has a scan prescaler, a digit counter, one anti-ghosting dead cycle per digit switch, and optional leading-zero blanking. All outputs are registered.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2. Default gives 1 kHz at 50 MHz.
- `BLANK_LZ`, default 0: 1 blanks leading zero digits.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  16  value to capture (generator output).
- `load`  in  1  capture request, level; already synchronous and debounced upstream.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low; `an[0]` is the least-significant nibble.
- `shown`  out  16  currently latched value.

## Operation
- Reset values:
  - `seg` = 7'h7F, `an` = 4'hF, `shown` = 16'h0000.
  - Prescaler = 0, digit index = 0, `load_q` = 0.
- Capture:
  - `load_q` registers `load`.
  - Capture fires on `load & ~load_q`: `shown <= data` on that edge.
  - A held-high `load` captures once only.
  - `load` high when reset releases counts as a rising edge on the first clock.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` = (cnt == SCAN_DIV-1).
  - Width is $clog2(SCAN_DIV).
- Digit index: 2 bits; on `tick` it increments modulo 4 (3 → 0).
- Output register, evaluated every cycle:
  - If `tick`: `an <= 4'hF`, `seg <= 7'h7F` (dead cycle).
  - Otherwise: `an <= ~(4'b0001 << idx)` and `seg <= pattern(shown[4*idx+3 : 4*idx])`.
  - If the digit is blanked: `an` is still driven as above, but `seg <= 7'h7F`.
- Patterns, 0..F:
  - 0–7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8–F: 00, 10, 08, 03, 46, 21, 06, 0E
- Blanking (only when BLANK_LZ = 1):
  - Digit k is blanked if it and every higher nibble of `shown` are zero.
  - Digit 0 is never blanked, so 16'h0000 shows a single "0".

## Timing
- First clock after reset release: `an` = 4'b1110, `seg` = 7'h40.
- Each digit is lit for SCAN_DIV-1 cycles, followed by 1 dead cycle. Full refresh period = 4·SCAN_DIV cycles.
- Capture latency: `load` rises at edge N, so `shown` updates at edge N.
  - `seg` reflects the new value at edge N+1, unless N+1 is a dead cycle.
- Capture coinciding with `tick`: both take effect in the same cycle. The next lit digit shows the new value.
- `data` changing without a `load` edge has no effect.
- Reset asserted mid-scan: all state and outputs return to reset values immediately (asynchronously). Scanning restarts from digit 0 on release.

## Structure
- Shared package `hex_disp_pkg` holds:
  - the 16 segment pattern constants;
  - `SEG_OFF` (7'h7F) and `AN_OFF` (4'hF).
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit decoder, instanced once on the selected nibble.
- The prescaler, digit counter, edge detector, blanking logic and output register live in `hex_scan_disp`.

## Test plan
Bench uses SCAN_DIV = 4.
- Reset release with `load` = 0 → `an` = E, `seg` = 40 at edge 1. `an` = F at the cycle where cnt = 3. `an` then steps D, B, 7, E, with a dead cycle before each step.
- `data` = 16'hA5C3, pulse `load` for 1 cycle → `shown` = A5C3. Per digit, `seg` = 30 (digit 0), 46, 12, 08 (digit 3).
- Hold `load` high for 20 cycles while `data` changes to 16'h1234 mid-hold → `shown` keeps the value captured on the first edge.
- BLANK_LZ = 1, `data` = 16'h0070 → digits 3 and 2 show `seg` = 7F with `an` still cycling; digit 1 shows 78, digit 0 shows 40.
- BLANK_LZ = 1, `data` = 16'h0000 → digit 0 shows 40; digits 1–3 show 7F.
- Assert `rst_n` low while digit 2 is lit with `shown` = FFFF → `an` = F, `seg` = 7F, `shown` = 0 asynchronously, before the next clock edge.
